// File: rtl/receptor_pcs.sv
// receptor_pcs: 1000BASE-X PCS receive path. It decodes 8b/10b and runs the receive
// state machine, driving registered GMII-style RXD/RX_DV/RX_ER one cycle after each accepted group.
//
// state      | meaning
// WAIT_FOR_K | hunting for K28.5 on an even position
// RX_K       | comma seen, expecting the data half of /I/ or /C/
// IDLE_D     | ordered set complete, waiting for K28.5 or /S/
// RECEIVE    | inside a frame, forwarding data octets
// TRI_RRI    | /T/ seen, expecting /R/
// EXT_R      | carrier extension (/R/ stream) after end of frame
module receptor_pcs #(
  parameter logic [7:0] SOP_OCTET = 8'h55
) (
  input  logic       GTX_CLK,
  input  logic       RESET,
  input  logic       SUDI,
  input  logic [9:0] rx_code_group,
  input  logic       rx_even,
  input  logic       sync_status,
  output logic [7:0] RXD,
  output logic       RX_DV,
  output logic       RX_ER
);
  localparam logic [2:0] WAIT_FOR_K = 3'd0;
  localparam logic [2:0] RX_K       = 3'd1;
  localparam logic [2:0] IDLE_D     = 3'd2;
  localparam logic [2:0] RECEIVE    = 3'd3;
  localparam logic [2:0] TRI_RRI    = 3'd4;
  localparam logic [2:0] EXT_R      = 3'd5;

  logic [2:0] state_q, state_d;
  logic [7:0] rxd_q, rxd_d;
  logic       rx_dv_q, rx_dv_d;
  logic       rx_er_q, rx_er_d;

  logic [5:0] cg6;
  logic [3:0] cg4;
  logic [4:0] dec5;
  logic [2:0] dec3;
  logic       dec5_ok, dec3_ok;
  logic       is_k28, is_k285, is_s, is_t, is_r, is_k307, is_k, is_data;

  assign cg6 = rx_code_group[9:4];
  assign cg4 = rx_code_group[3:0];

  // Both running-disparity columns map to the same EDCBA value.
  always_comb begin
    dec5    = 5'd0;
    dec5_ok = 1'b1;
    case (cg6)
      6'b100111, 6'b011000: dec5 = 5'd0;
      6'b011101, 6'b100010: dec5 = 5'd1;
      6'b101101, 6'b010010: dec5 = 5'd2;
      6'b110001:            dec5 = 5'd3;
      6'b110101, 6'b001010: dec5 = 5'd4;
      6'b101001:            dec5 = 5'd5;
      6'b011001:            dec5 = 5'd6;
      6'b111000, 6'b000111: dec5 = 5'd7;
      6'b111001, 6'b000110: dec5 = 5'd8;
      6'b100101:            dec5 = 5'd9;
      6'b010101:            dec5 = 5'd10;
      6'b110100:            dec5 = 5'd11;
      6'b001101:            dec5 = 5'd12;
      6'b101100:            dec5 = 5'd13;
      6'b011100:            dec5 = 5'd14;
      6'b010111, 6'b101000: dec5 = 5'd15;
      6'b011011, 6'b100100: dec5 = 5'd16;
      6'b100011:            dec5 = 5'd17;
      6'b010011:            dec5 = 5'd18;
      6'b110010:            dec5 = 5'd19;
      6'b001011:            dec5 = 5'd20;
      6'b101010:            dec5 = 5'd21;
      6'b011010:            dec5 = 5'd22;
      6'b111010, 6'b000101: dec5 = 5'd23;
      6'b110011, 6'b001100: dec5 = 5'd24;
      6'b100110:            dec5 = 5'd25;
      6'b010110:            dec5 = 5'd26;
      6'b110110, 6'b001001: dec5 = 5'd27;
      6'b001110:            dec5 = 5'd28;
      6'b101110, 6'b010001: dec5 = 5'd29;
      6'b011110, 6'b100001: dec5 = 5'd30;
      6'b101011, 6'b010100: dec5 = 5'd31;
      default:              dec5_ok = 1'b0;
    endcase
  end

  // Primary and alternate x.7 forms both decode to HGF=7.
  always_comb begin
    dec3    = 3'd0;
    dec3_ok = 1'b1;
    case (cg4)
      4'b1011, 4'b0100:                   dec3 = 3'd0;
      4'b1001:                            dec3 = 3'd1;
      4'b0101:                            dec3 = 3'd2;
      4'b1100, 4'b0011:                   dec3 = 3'd3;
      4'b1101, 4'b0010:                   dec3 = 3'd4;
      4'b1010:                            dec3 = 3'd5;
      4'b0110:                            dec3 = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: dec3 = 3'd7;
      default:                            dec3_ok = 1'b0;
    endcase
  end

  // Legal fghj tails after a 001111 K28 prefix; the 110000 prefix uses their complements.
  function automatic logic k28_tail(input logic [3:0] t);
    case (t)
      4'b0100, 4'b1001, 4'b0101, 4'b0011,
      4'b0010, 4'b1010, 4'b0110, 4'b1000: k28_tail = 1'b1;
      default:                            k28_tail = 1'b0;
    endcase
  endfunction

  assign is_k28  = ((cg6 == 6'b001111) && k28_tail(cg4)) ||
                   ((cg6 == 6'b110000) && k28_tail(~cg4));
  assign is_k285 = (rx_code_group == 10'b0011111010) || (rx_code_group == 10'b1100000101);
  assign is_s    = (rx_code_group == 10'b1101101000) || (rx_code_group == 10'b0010010111);
  assign is_t    = (rx_code_group == 10'b1011101000) || (rx_code_group == 10'b0100010111);
  assign is_r    = (rx_code_group == 10'b1110101000) || (rx_code_group == 10'b0001010111);
  assign is_k307 = (rx_code_group == 10'b0111101000) || (rx_code_group == 10'b1000010111);
  assign is_k    = is_k28 | is_s | is_t | is_r | is_k307;
  // Kx.7 shares its 6b half with data, so a K match takes priority.
  assign is_data = dec5_ok & dec3_ok & ~is_k;

  always_comb begin
    state_d = state_q;
    rxd_d   = rxd_q;
    rx_dv_d = rx_dv_q;
    rx_er_d = rx_er_q;
    if (!sync_status) begin
      state_d = WAIT_FOR_K;
      rxd_d   = 8'h00;
      rx_dv_d = 1'b0;
      rx_er_d = 1'b0;
    end else if (SUDI) begin
      rxd_d   = 8'h00;
      rx_dv_d = 1'b0;
      rx_er_d = 1'b0;
      case (state_q)
        WAIT_FOR_K: if (is_k285 && rx_even) state_d = RX_K;
        RX_K:       state_d = is_data ? IDLE_D : WAIT_FOR_K;
        IDLE_D: begin
          if (is_k285) begin
            state_d = RX_K;
          end else if (is_s) begin
            state_d = RECEIVE;
            rx_dv_d = 1'b1;
            rxd_d   = SOP_OCTET;
          end else begin
            state_d = WAIT_FOR_K;
          end
        end
        RECEIVE: begin
          if (is_data) begin
            rx_dv_d = 1'b1;
            rxd_d   = {dec3, dec5};
          end else if (is_t) begin
            state_d = TRI_RRI;
          end else if (is_k285) begin
            state_d = RX_K;
            rx_er_d = 1'b1;
          end else begin
            rx_dv_d = 1'b1;
            rx_er_d = 1'b1;
          end
        end
        TRI_RRI: begin
          if (is_r) begin
            state_d = EXT_R;
          end else begin
            state_d = WAIT_FOR_K;
            rx_er_d = 1'b1;
          end
        end
        EXT_R: begin
          if (is_r) begin
            rx_er_d = 1'b1;
            rxd_d   = 8'h0F;
          end else if (is_k285 && rx_even) begin
            state_d = RX_K;
          end else begin
            state_d = WAIT_FOR_K;
            rx_er_d = 1'b1;
          end
        end
        default: state_d = WAIT_FOR_K;
      endcase
    end
  end

  always_ff @(posedge GTX_CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= WAIT_FOR_K;
      rxd_q   <= 8'h00;
      rx_dv_q <= 1'b0;
      rx_er_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rxd_q   <= rxd_d;
      rx_dv_q <= rx_dv_d;
      rx_er_q <= rx_er_d;
    end
  end

  assign RXD   = rxd_q;
  assign RX_DV = rx_dv_q;
  assign RX_ER = rx_er_q;
endmodule
